// File: rtl/move_scan.sv
// move_scan: walks the all_moves list, evaluates each move and keeps the best one for the side to move.
//   in : clk, reset_n (async active-low), moves_ready, move_count, mate, stalemate,
//        white_to_move, eval, eval_valid
//   out: move_index, eval_start, clear_eval, clear_moves, best_index, best_eval,
//        status (0 ok, 1 mate, 2 stalemate, 3 eval timeout), scan_done, busy
module move_scan #(
    parameter int MAX_POSITIONS_LOG2 = 8,
    parameter int EVAL_WIDTH         = 22,
    parameter int RAM_LATENCY        = 1,
    parameter int EVAL_TIMEOUT       = 256
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0]       move_count,
    input  logic                                mate,
    input  logic                                stalemate,
    input  logic                                white_to_move,
    input  logic signed [EVAL_WIDTH-1:0]        eval,
    input  logic                                eval_valid,
    output logic [MAX_POSITIONS_LOG2-1:0]       move_index,
    output logic                                eval_start,
    output logic                                clear_eval,
    output logic                                clear_moves,
    output logic [MAX_POSITIONS_LOG2-1:0]       best_index,
    output logic signed [EVAL_WIDTH-1:0]        best_eval,
    output logic [1:0]                          status,
    output logic                                scan_done,
    output logic                                busy
);
    localparam int MW   = MAX_POSITIONS_LOG2;
    localparam int WD_W = EVAL_TIMEOUT > 1 ? $clog2(EVAL_TIMEOUT) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] EVAL_WAIT = 3'd2;
    localparam logic [2:0] COMPARE   = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;
    localparam logic [2:0] FLUSH     = 3'd5;

    logic [2:0]                  state_q, state_d;
    logic [2:0]                  lat_q, lat_d;
    logic [WD_W-1:0]             wd_q, wd_d;
    logic [MW-1:0]               move_index_q, move_index_d;
    logic [MW-1:0]               best_index_q, best_index_d;
    logic signed [EVAL_WIDTH-1:0] best_eval_q, best_eval_d;
    logic [1:0]                  status_q, status_d;
    logic                        first_q, first_d;
    logic                        take;
    logic [MW:0]                 next_index;

    // one extra bit so move_index+1 never wraps before comparing with move_count
    assign next_index = {1'b0, move_index_q} + 1'b1;

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        wd_d         = wd_q;
        move_index_d = move_index_q;
        best_index_d = best_index_q;
        best_eval_d  = best_eval_q;
        status_d     = status_q;
        first_d      = first_q;
        eval_start   = 1'b0;
        clear_eval   = 1'b0;
        take         = 1'b0;
        case (state_q)
            IDLE: begin
                move_index_d = '0;
                if (moves_ready) begin
                    if (move_count == '0) begin
                        state_d  = DONE;
                        status_d = mate ? 2'd1 : 2'd2;
                    end else begin
                        state_d  = ADDR;
                        lat_d    = '0;
                        status_d = 2'd0;
                        first_d  = 1'b1;
                    end
                end
            end
            ADDR: begin
                lat_d = lat_q + 3'd1;
                if (lat_q == 3'(RAM_LATENCY - 1)) begin
                    eval_start = 1'b1;
                    state_d    = EVAL_WAIT;
                    wd_d       = '0;
                end
            end
            EVAL_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (eval_valid) begin
                    state_d = COMPARE;
                end else if (EVAL_TIMEOUT != 0 && wd_q == WD_W'(EVAL_TIMEOUT - 1)) begin
                    status_d   = 2'd3;
                    clear_eval = 1'b1;
                    state_d    = DONE;
                end
            end
            COMPARE: begin
                // strict compare: equal evals keep the earlier move
                take       = first_q || (white_to_move ? (eval > best_eval_q) : (eval < best_eval_q));
                clear_eval = 1'b1;
                if (take) begin
                    best_index_d = move_index_q;
                    best_eval_d  = eval;
                    first_d      = 1'b0;
                end
                if (next_index < {1'b0, move_count}) begin
                    move_index_d = next_index[MW-1:0];
                    lat_d        = '0;
                    state_d      = ADDR;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            wd_q         <= '0;
            move_index_q <= '0;
            best_index_q <= '0;
            best_eval_q  <= '0;
            status_q     <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            wd_q         <= wd_d;
            move_index_q <= move_index_d;
            best_index_q <= best_index_d;
            best_eval_q  <= best_eval_d;
            status_q     <= status_d;
            first_q      <= first_d;
        end
    end

    assign move_index  = move_index_q;
    assign best_index  = best_index_q;
    assign best_eval   = best_eval_q;
    assign status      = status_q;
    assign scan_done   = state_q == DONE;
    assign clear_moves = state_q == DONE;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_move_scan.sv
// tb_move_scan: directed scoreboard bench for move_scan with RAM_LATENCY=3, EVAL_TIMEOUT=16.
module tb_move_scan;
    typedef struct {
        int unsigned idx;
        int          ev;
        int unsigned st;
        bit          chk_best;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              moves_ready = 1'b0;
    logic [7:0]        move_count = '0;
    logic              mate = 1'b0;
    logic              stalemate = 1'b0;
    logic              white_to_move = 1'b0;
    logic signed [21:0] eval = '0;
    logic              eval_valid = 1'b0;
    logic [7:0]        move_index;
    logic              eval_start;
    logic              clear_eval;
    logic              clear_moves;
    logic [7:0]        best_index;
    logic signed [21:0] best_eval;
    logic [1:0]        status;
    logic              scan_done;
    logic              busy;

    exp_t              q[$];
    int                checks = 0;
    int                fails = 0;
    int                n_done = 0;
    int                n_start = 0;
    int                last_wait = 0;
    int                wcnt = 0;
    bit                armed = 0;
    int                since = 0;
    logic [7:0]        prev_idx = '0;
    logic              prev_busy = 1'b0;
    int                resp_limit = 8;
    logic signed [21:0] tab [0:7];

    always #5 clk = ~clk;

    move_scan #(
        .MAX_POSITIONS_LOG2(8),
        .EVAL_WIDTH(22),
        .RAM_LATENCY(3),
        .EVAL_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .moves_ready(moves_ready),
        .move_count(move_count),
        .mate(mate),
        .stalemate(stalemate),
        .white_to_move(white_to_move),
        .eval(eval),
        .eval_valid(eval_valid),
        .move_index(move_index),
        .eval_start(eval_start),
        .clear_eval(clear_eval),
        .clear_moves(clear_moves),
        .best_index(best_index),
        .best_eval(best_eval),
        .status(status),
        .scan_done(scan_done),
        .busy(busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: timing checks on every cycle, scoreboard pop on scan_done
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && busy && (!prev_busy || move_index != prev_idx)) since = 1;
        else since++;
        prev_idx  = move_index;
        prev_busy = busy;
        if (!reset_n) armed = 0;
        if (eval_start) begin
            n_start++;
            check("eval_start_latency", since, 3);
        end
        if (eval_start || clear_eval) check("start_clear_exclusive", longint'(eval_start && clear_eval), 0);
        if (eval_start) begin
            armed = 1;
            wcnt  = 0;
        end else if (armed) begin
            wcnt++;
            if (clear_eval) begin
                armed     = 0;
                last_wait = wcnt;
            end
        end
        if (scan_done) begin
            n_done++;
            check("clear_moves_with_done", longint'(clear_moves), 1);
            if (q.size() == 0) begin
                check("unexpected_scan_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("status", longint'(status), longint'(e.st));
                if (e.chk_best) begin
                    check("best_index", longint'(best_index), longint'(e.idx));
                    check("best_eval", longint'(best_eval), longint'(e.ev));
                end
            end
        end
    end

    // evaluate model: answers two cycles after eval_start, holds eval_valid until clear_eval
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            if (!reset_n || clear_eval) eval_valid = 1'b0;
            if (reset_n && eval_start) begin
                idx = int'(move_index);
                if (idx < resp_limit) begin
                    repeat (2) @(negedge clk);
                    eval       = tab[idx];
                    eval_valid = 1'b1;
                end
            end
        end
    end

    task automatic run_scan(input int cnt, input bit wtm, input bit m, input bit s,
                            input exp_t e, output int k);
        @(negedge clk);
        move_count    = 8'(cnt);
        white_to_move = wtm;
        mate          = m;
        stalemate     = s;
        q.push_back(e);
        moves_ready   = 1'b1;
        k = 0;
        while (!scan_done && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!scan_done) begin
            checks++;
            fails++;
            $display("FAIL scan_wait: no scan_done within %0d cycles", k);
        end
        moves_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_move_index"}, longint'(move_index), 0);
        check({tag, "_best_index"}, longint'(best_index), 0);
        check({tag, "_best_eval"}, longint'(best_eval), 0);
        check({tag, "_status"}, longint'(status), 0);
        check({tag, "_pulses"}, longint'({eval_start, clear_eval, clear_moves, scan_done}), 0);
        check({tag, "_busy"}, longint'(busy), 0);
    endtask

    initial begin
        int k;
        int s0;
        int d0;
        for (int i = 0; i < 8; i++) tab[i] = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // maximise over {5,-2,9}
        tab[0] = 22'sd5; tab[1] = -22'sd2; tab[2] = 22'sd9;
        s0 = n_start;
        run_scan(3, 1'b1, 1'b0, 1'b0, '{2, 9, 0, 1'b1}, k);
        check("t1_eval_starts", n_start - s0, 3);
        check("t1_idle_after", longint'(busy), 0);

        // minimise over the same list
        run_scan(3, 1'b0, 1'b0, 1'b0, '{1, -2, 0, 1'b1}, k);

        // tie keeps the lower index
        tab[0] = 22'sd4; tab[1] = 22'sd4; tab[2] = 22'sd1;
        run_scan(3, 1'b1, 1'b0, 1'b0, '{0, 4, 0, 1'b1}, k);

        // minimise over a longer list with large negative values
        tab[0] = 22'sd100; tab[1] = -22'sd2097152; tab[2] = 22'sd0; tab[3] = -22'sd2097152;
        run_scan(4, 1'b0, 1'b0, 1'b0, '{1, -2097152, 0, 1'b1}, k);

        // empty list: mate, then stalemate
        s0 = n_start;
        run_scan(0, 1'b1, 1'b1, 1'b0, '{0, 0, 1, 1'b0}, k);
        check("mate_done_latency", k, 1);
        run_scan(0, 1'b1, 1'b0, 1'b1, '{0, 0, 2, 1'b0}, k);
        check("stalemate_done_latency", k, 1);
        check("empty_no_eval_start", n_start - s0, 0);

        // evaluate never answers: timeout on the 16th EVAL_WAIT cycle
        resp_limit = 0;
        s0 = n_start;
        run_scan(1, 1'b1, 1'b0, 1'b0, '{0, 0, 3, 1'b0}, k);
        check("timeout_wait_cycles", last_wait, 16);
        check("timeout_eval_starts", n_start - s0, 1);

        // reset in the middle of EVAL_WAIT for the second move
        resp_limit = 1;
        tab[0] = 22'sd7;
        d0 = n_done;
        @(negedge clk);
        move_count    = 8'd3;
        white_to_move = 1'b1;
        moves_ready   = 1'b1;
        k = 0;
        while (!(eval_start && move_index == 8'd1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_reached_index1", longint'(eval_start && move_index == 8'd1), 1);
        repeat (4) @(negedge clk);
        check("rst_pre_busy", longint'(busy), 1);
        check("rst_pre_best_eval", longint'(best_eval), 7);
        #2 reset_n = 1'b0;
        #1 check_zero("midscan_reset");
        moves_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_scan_done", n_done - d0, 0);

        check("total_scan_done", n_done, 7);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
